// File: rtl/ram_bus_pkg.sv
// Shared definitions for the RAM bus samplers: bus-vector layout and the
// capture FSM state encoding.
package ram_bus_pkg;

    localparam int CTRL_W     = 5;
    localparam int BIT_ALATCH = 0;
    localparam int BIT_WRITE  = 1;
    localparam int BIT_READ   = 2;
    localparam int BIT_LB     = 3;
    localparam int BIT_UB     = 4;

    // Bus vector is {addr, data, ub, lb, read, write, addr_latch}, LSB last.
    function automatic int bus_w(input int aw, input int dw);
        return aw + dw + CTRL_W;
    endfunction

    function automatic int addr_lsb(input int dw);
        return CTRL_W + dw;
    endfunction

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        OUTPUT = 2'd2
    } cap_state_t;

endpackage

// File: rtl/mdetect_n_arr.sv
// Bit-wise majority vote over NSAMP snapshots, plus a per-bit flag that is
// set when every snapshot agreed on that bit.
module mdetect_n_arr #(
    parameter int W     = 8,
    parameter int NSAMP = 3
) (
    input  logic [NSAMP-1:0][W-1:0] snap,
    output logic [W-1:0]            vote,
    output logic [W-1:0]            unanimous
);

    localparam int CW = $clog2(NSAMP + 1);

    for (genvar b = 0; b < W; b++) begin : g_bit
        logic [CW-1:0] ones;

        always_comb begin
            ones = '0;
            for (int k = 0; k < NSAMP; k++)
                ones = ones + CW'(snap[k][b]);
        end

        assign vote[b]      = (ones > CW'(NSAMP / 2));
        assign unanimous[b] = (ones == '0) || (ones == CW'(NSAMP));
    end

endmodule

// File: rtl/ram_sampler_n.sv
// PSRAM bus front end: synchronises the raw bus, qualifies ram_clk edges over a
// stability window and emits a majority-voted snapshot set with a strobe.
module ram_sampler_n
    import ram_bus_pkg::*;
#(
    parameter int ADDR_W     = 23,
    parameter int DATA_W     = 16,
    parameter int NSAMP      = 3,
    parameter int SPACING    = 2,
    parameter int MIN_STABLE = 2
) (
    input  logic              mclk,
    input  logic              reset,
    input  logic              enable,
    input  logic              edge_sel,
    input  logic [ADDR_W-1:0] ram_a,
    input  logic [DATA_W-1:0] ram_d,
    input  logic              ram_oe,
    input  logic              ram_we,
    input  logic              ram_ce1,
    input  logic              ram_ub,
    input  logic              ram_lb,
    input  logic              ram_adv,
    input  logic              ram_ce2,
    input  logic              ram_clk,
    output logic [ADDR_W-1:0] filter_a,
    output logic [DATA_W-1:0] filter_d,
    output logic [1:0]        filter_ublb,
    output logic              filter_read,
    output logic              filter_write,
    output logic              filter_addr_latch,
    output logic              filter_strobe,
    output logic              filter_glitch,
    output logic              overrun
);

    localparam int W     = bus_w(ADDR_W, DATA_W);
    localparam int A_LSB = addr_lsb(DATA_W);
    localparam int HIST  = 2 * MIN_STABLE;
    localparam int DEPTH = 2 + HIST;
    localparam int KW    = (NSAMP > 1) ? $clog2(NSAMP) : 1;
    localparam int SW    = (SPACING > 1) ? $clog2(SPACING) : 1;

    logic         chip_en;
    logic [W-1:0] bus_raw;

    assign chip_en = !ram_ce1 && ram_ce2;
    assign bus_raw = {ram_a, ram_d, !ram_ub, !ram_lb,
                      !ram_oe && chip_en, !ram_we && chip_en, !ram_adv && chip_en};

    // Bus pipe is as deep as sync + history so a snapshot lines up with the
    // oldest clock sample the edge decision was based on.
    logic [1:0]               clk_sync;
    logic [HIST-1:0]          hist;
    logic [DEPTH-1:0][W-1:0]  bus_pipe;
    logic [W-1:0]             bus_dly;

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            clk_sync <= '0;
            hist     <= '0;
            bus_pipe <= '0;
        end else begin
            clk_sync <= {clk_sync[0], ram_clk};
            hist     <= {hist[HIST-2:0], clk_sync[1]};
            bus_pipe <= {bus_pipe[DEPTH-2:0], bus_raw};
        end
    end

    assign bus_dly = bus_pipe[DEPTH-1];

    logic [MIN_STABLE-1:0] new_lvl, old_lvl;
    logic                  rise, fall, qual;

    assign new_lvl = hist[MIN_STABLE-1:0];
    assign old_lvl = hist[HIST-1:MIN_STABLE];
    assign rise    = (&new_lvl) && !(|old_lvl);
    assign fall    = !(|new_lvl) && (&old_lvl);
    assign qual    = edge_sel ? fall : rise;

    cap_state_t  state, state_nx;
    logic [KW-1:0] k, k_nx;
    logic [SW-1:0] sp, sp_nx;
    logic          latch, finish;

    always_comb begin
        state_nx = state;
        k_nx     = k;
        sp_nx    = sp;
        latch    = 1'b0;
        finish   = 1'b0;
        overrun  = 1'b0;
        if (!enable) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE, OUTPUT: begin
                    if (qual) begin
                        state_nx = SAMPLE;
                        k_nx     = '0;
                        sp_nx    = '0;
                    end else begin
                        state_nx = IDLE;
                    end
                end
                SAMPLE: begin
                    overrun = qual;
                    if (sp == '0) begin
                        latch = 1'b1;
                        if (k == KW'(NSAMP - 1)) begin
                            finish   = 1'b1;
                            state_nx = OUTPUT;
                        end else begin
                            k_nx  = k + 1'b1;
                            sp_nx = SW'(SPACING - 1);
                        end
                    end else begin
                        sp_nx = sp - 1'b1;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // The final snapshot bypasses its register so the strobe lands in the
    // OUTPUT cycle itself.
    logic [NSAMP-1:0][W-1:0] snap, vote_in;
    logic [W-1:0]            vote, unanimous;

    always_comb begin
        vote_in = snap;
        if (latch)
            vote_in[k] = bus_dly;
    end

    mdetect_n_arr #(.W(W), .NSAMP(NSAMP)) u_vote (
        .snap      (vote_in),
        .vote      (vote),
        .unanimous (unanimous)
    );

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            k                 <= '0;
            sp                <= '0;
            snap              <= '0;
            filter_a          <= '0;
            filter_d          <= '0;
            filter_ublb       <= '0;
            filter_read       <= 1'b0;
            filter_write      <= 1'b0;
            filter_addr_latch <= 1'b0;
            filter_strobe     <= 1'b0;
            filter_glitch     <= 1'b0;
        end else begin
            state         <= state_nx;
            k             <= k_nx;
            sp            <= sp_nx;
            filter_strobe <= finish;
            if (latch)
                snap[k] <= bus_dly;
            if (finish) begin
                filter_a          <= vote[A_LSB +: ADDR_W];
                filter_d          <= vote[CTRL_W +: DATA_W];
                filter_ublb       <= {vote[BIT_UB], vote[BIT_LB]};
                filter_read       <= vote[BIT_READ];
                filter_write      <= vote[BIT_WRITE];
                filter_addr_latch <= vote[BIT_ALATCH];
                filter_glitch     <= !(&unanimous);
            end
        end
    end

endmodule
